// File: rtl/fetch_controller_pkg.sv
// Shared CPU package for the fetch slice.
// Provides the datapath width, the reset/NOP defaults used by the fetch
// controller, the fetch FSM state type and a word-alignment helper.
package fetch_controller_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [XLEN-1:0] RESET_PC_DEFAULT  = 32'h0000_0000;
   localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT,
      ST_HOLD
   } fetch_state_t;

   // Clears the byte-offset bits so every fetch address is word aligned.
   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
      return addr & ~XLEN'(3);
   endfunction

endpackage

// File: rtl/fetch_controller.sv
// Instruction fetch controller.
// Issues one instruction-memory request at a time, waits for the read
// response, and presents the fetched word to decode until it is accepted.
// Redirects override every other event and discard any in-flight fetch.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   imem_req/imem_addr  fetch request and word-aligned address
//   imem_gnt            memory accepts the request this cycle
//   imem_rvalid/rdata   read response
//   redirect_valid/pc   branch/jump redirect
//   instr_valid/instr/instr_pc  instruction presented to decode
//   instr_ready         decode accepts the instruction
module fetch_controller
   import fetch_controller_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
   parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
   input  logic            clk,
   input  logic            reset,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            instr_valid,
   output logic [XLEN-1:0] instr,
   output logic [XLEN-1:0] instr_pc,
   input  logic            instr_ready
);

   fetch_state_t    state;
   logic [XLEN-1:0] pc;
   // Set when the outstanding transaction belongs to a stale fetch stream.
   logic            drop;

   // Request is a pure decode of the state register: no path from imem_gnt.
   assign imem_req  = (state == ST_REQ);
   assign imem_addr = pc;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         pc          <= RESET_PC;
         drop        <= 1'b0;
         instr_valid <= 1'b0;
         instr       <= NOP_INSTR;
         instr_pc    <= RESET_PC;
      end else if (redirect_valid) begin
         pc          <= word_align(redirect_pc);
         instr_valid <= 1'b0;
         case (state)
            ST_IDLE: state <= ST_REQ;
            ST_REQ: begin
               // A request granted together with the redirect is still in
               // flight; its response must be swallowed.
               if (imem_gnt) begin
                  state <= ST_WAIT;
                  drop  <= 1'b1;
               end
            end
            ST_WAIT: begin
               if (imem_rvalid) begin
                  state <= ST_REQ;
                  drop  <= 1'b0;
               end else begin
                  drop  <= 1'b1;
               end
            end
            ST_HOLD: state <= ST_REQ;
            default: state <= ST_IDLE;
         endcase
      end else begin
         case (state)
            ST_IDLE: state <= ST_REQ;
            ST_REQ: begin
               if (imem_gnt) state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (imem_rvalid) begin
                  if (drop) begin
                     drop  <= 1'b0;
                     state <= ST_REQ;
                  end else begin
                     instr       <= imem_rdata;
                     instr_pc    <= pc;
                     instr_valid <= 1'b1;
                     pc          <= pc + XLEN'(4);
                     state       <= ST_HOLD;
                  end
               end
            end
            ST_HOLD: begin
               if (instr_ready) begin
                  instr_valid <= 1'b0;
                  state       <= ST_REQ;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller: directed scenarios followed by
// randomized traffic, all compared against a transaction-level model.
module tb_fetch_controller;
   import fetch_controller_pkg::*;

   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_ready;

   always #5 clk = ~clk;

   fetch_controller #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
      .clk            (clk),
      .reset          (reset),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_gnt       (imem_gnt),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .instr_valid    (instr_valid),
      .instr          (instr),
      .instr_pc       (instr_pc),
      .instr_ready    (instr_ready)
   );

   int checks = 0;
   int errors = 0;

   // Transaction-level model: next address of the fetch stream, one
   // outstanding memory transaction (possibly stale), one delivered word.
   logic        m_after_rst;
   logic        m_out;
   logic        m_stale;
   logic [31:0] m_addr;
   logic [31:0] m_pc;
   logic        m_valid;
   logic [31:0] m_instr;
   logic [31:0] m_ipc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_after_rst = 1'b1;
      m_out       = 1'b0;
      m_stale     = 1'b0;
      m_addr      = RST_PC;
      m_pc        = RST_PC;
      m_valid     = 1'b0;
      m_instr     = NOP;
      m_ipc       = RST_PC;
   endtask

   task automatic idle_inputs();
      reset          = 1'b0;
      imem_gnt       = 1'b0;
      imem_rvalid    = 1'b0;
      imem_rdata     = 32'hDEAD_BEEF;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      instr_ready    = 1'b0;
   endtask

   // Check current outputs, advance the model with the inputs now applied,
   // then let the clock edge happen.
   task automatic cycle();
      logic exp_req;
      logic accept;
      logic resp;
      // A request is expected whenever nothing is in flight or held and
      // the controller is not in its post-reset idle cycle.
      exp_req = !m_after_rst && !m_out && !m_valid;
      chk("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
      if (exp_req) chk("imem_addr", imem_addr, m_pc);
      chk("instr_valid", {31'b0, instr_valid}, {31'b0, m_valid});
      chk("instr", instr, m_instr);
      chk("instr_pc", instr_pc, m_ipc);

      if (reset) begin
         model_reset();
      end else begin
         m_after_rst = 1'b0;
         accept = exp_req && imem_gnt;
         resp   = m_out && imem_rvalid;
         if (redirect_valid) begin
            m_pc    = redirect_pc & ~32'd3;
            m_valid = 1'b0;
            if (accept) begin
               m_out   = 1'b1;
               m_stale = 1'b1;
            end else if (resp) begin
               m_out   = 1'b0;
               m_stale = 1'b0;
            end else if (m_out) begin
               m_stale = 1'b1;
            end
         end else begin
            if (m_valid && instr_ready) m_valid = 1'b0;
            if (accept) begin
               m_out   = 1'b1;
               m_stale = 1'b0;
               m_addr  = m_pc;
            end else if (resp) begin
               m_out = 1'b0;
               if (!m_stale) begin
                  m_valid = 1'b1;
                  m_instr = imem_rdata;
                  m_ipc   = m_addr;
                  m_pc    = m_addr + 32'd4;
               end
               m_stale = 1'b0;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      idle_inputs();
      reset = 1'b1;
      model_reset();
      @(posedge clk);
      #1;

      // Reset held a second cycle, then release.
      cycle();
      chk("rst_instr", instr, NOP);
      chk("rst_instr_pc", instr_pc, RST_PC);
      chk("rst_req", {31'b0, imem_req}, 32'd0);
      idle_inputs();
      cycle();                               // IDLE
      chk("first_req", {31'b0, imem_req}, 32'd1);
      chk("first_addr", imem_addr, 32'h0);

      // Minimum-latency fetch.
      imem_gnt = 1'b1; cycle(); idle_inputs();
      imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093; cycle(); idle_inputs();
      chk("lat_valid", {31'b0, instr_valid}, 32'd1);
      chk("lat_instr", instr, 32'h0050_0093);
      chk("lat_pc", instr_pc, 32'h0);
      instr_ready = 1'b1; cycle(); idle_inputs();
      chk("next_addr", imem_addr, 32'h4);

      // Grant withheld three cycles.
      for (int i = 0; i < 3; i++) cycle();
      chk("held_addr", imem_addr, 32'h4);
      imem_gnt = 1'b1; cycle(); idle_inputs();
      imem_rvalid = 1'b1; imem_rdata = 32'h1234_5678; cycle(); idle_inputs();

      // Decode stalls five cycles in HOLD.
      for (int i = 0; i < 5; i++) cycle();
      chk("stall_instr", instr, 32'h1234_5678);
      instr_ready = 1'b1; cycle(); idle_inputs();
      chk("stall_next_addr", imem_addr, 32'h8);

      // Redirect while waiting, response arrives later and is discarded.
      imem_gnt = 1'b1; cycle(); idle_inputs();
      redirect_valid = 1'b1; redirect_pc = 32'h0000_0103; cycle(); idle_inputs();
      cycle();
      imem_rvalid = 1'b1; cycle(); idle_inputs();
      chk("redir_wait_valid", {31'b0, instr_valid}, 32'd0);
      chk("redir_wait_addr", imem_addr, 32'h0000_0100);

      // Redirect coincident with rvalid.
      imem_gnt = 1'b1; cycle(); idle_inputs();
      imem_rvalid = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
      cycle(); idle_inputs();
      chk("redir_rv_addr", imem_addr, 32'h0000_0200);

      // Redirect together with ready in HOLD.
      imem_gnt = 1'b1; cycle(); idle_inputs();
      imem_rvalid = 1'b1; imem_rdata = 32'hCAFE_0001; cycle(); idle_inputs();
      instr_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0300;
      cycle(); idle_inputs();
      chk("redir_hold_valid", {31'b0, instr_valid}, 32'd0);
      chk("redir_hold_addr", imem_addr, 32'h0000_0300);

      // Redirect in REQ to the top word, address wraps after the fetch.
      redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; cycle(); idle_inputs();
      chk("top_addr", imem_addr, 32'hFFFF_FFFC);
      imem_gnt = 1'b1; cycle(); idle_inputs();
      imem_rvalid = 1'b1; imem_rdata = 32'h0000_0073; cycle(); idle_inputs();
      chk("top_instr_pc", instr_pc, 32'hFFFF_FFFC);
      instr_ready = 1'b1; cycle(); idle_inputs();
      chk("wrap_addr", imem_addr, 32'h0);

      // Reset in WAIT, stray response afterwards.
      imem_gnt = 1'b1; cycle(); idle_inputs();
      reset = 1'b1; cycle(); idle_inputs();
      chk("mid_rst_req", {31'b0, imem_req}, 32'd0);
      imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_BAD0; cycle(); idle_inputs();
      chk("stray_valid", {31'b0, instr_valid}, 32'd0);
      chk("stray_addr", imem_addr, RST_PC);

      // Randomized traffic.
      for (int i = 0; i < 4000; i++) begin
         reset          = ($urandom_range(0, 199) == 0);
         redirect_valid = ($urandom_range(0, 11) == 0);
         redirect_pc    = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                                      : $urandom;
         imem_gnt       = 1'($urandom_range(0, 1));
         imem_rvalid    = m_out ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 9) == 0);
         imem_rdata     = $urandom;
         instr_ready    = ($urandom_range(0, 2) != 0);
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
